// File: rtl/dbg_mem_reader.sv
// Debug-port memory readback engine: holds the CPU, reads n_words words over the
// debug bus and streams them LSB-first as bytes into a valid/ready sink.
module dbg_mem_reader #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] n_words,
  output logic             busy,
  output logic             done,
  output logic             cpu_hold,
  output logic             dbg_mem_op,
  output logic [31:0]      dbg_adr,
  output logic [3:0]       dbg_wren,
  input  logic [31:0]      dbg_di,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND, S_FIN} state_t;

  state_t           state, state_nxt;
  logic [31:0]      addr;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      word;
  logic [1:0]       idx;
  logic [RD_LAT:0]  vld_pipe;
  logic             accept;
  logic             last_byte;
  logic             rd_done;

  // vld_pipe[k] is high k cycles after the READ cycle; data is valid at RD_LAT.
  assign vld_pipe[0] = (state == S_READ);
  assign rd_done     = (state == S_WAIT) && vld_pipe[RD_LAT];
  assign accept      = tx_valid && tx_ready;
  assign last_byte   = accept && (idx == 2'd3);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (n_words == '0) ? S_FIN : S_READ;
      S_READ: state_nxt = S_WAIT;
      S_WAIT: if (rd_done) state_nxt = S_SEND;
      S_SEND: if (last_byte) state_nxt = (cnt == CNT_W'(1)) ? S_FIN : S_READ;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state            <= S_IDLE;
      vld_pipe[RD_LAT:1] <= '0;
    end else begin
      state            <= state_nxt;
      vld_pipe[RD_LAT:1] <= vld_pipe[RD_LAT-1:0];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      addr <= '0;
      cnt  <= '0;
      word <= '0;
      idx  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        addr <= base_adr & 32'hFFFF_FFFC;
        cnt  <= n_words;
        idx  <= '0;
      end
      if (rd_done) begin
        word <= dbg_di;
        idx  <= '0;
      end
      if (state == S_SEND && accept) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          cnt <= cnt - CNT_W'(1);
          // address wraps modulo 2^32 by plain overflow
          if (cnt != CNT_W'(1)) addr <= addr + 32'd4;
        end
      end
    end
  end

  assign busy       = (state == S_READ) || (state == S_WAIT) || (state == S_SEND);
  assign cpu_hold   = busy;
  assign done       = (state == S_FIN);
  assign dbg_mem_op = (state == S_READ) || (state == S_WAIT);
  assign dbg_adr    = addr;
  assign dbg_wren   = 4'h0;
  assign tx_valid   = (state == S_SEND);
  assign tx_data    = (state == S_SEND) ? word[{idx, 3'b000} +: 8] : 8'h00;

endmodule
